// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller.
// Holds the controller state encoding (also shown on the status LEDs),
// the ALU operation codes and the operand/result widths.
package calc_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_GET_OP = 3'd3,
        S_EXEC   = 3'd4,
        S_SHOW   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/calc_seq_ctrl_btn_rise.sv
// Rising-edge detector for an already synchronised button level.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   lvl_i  - button level
//   rise_o - one-cycle pulse on a 0->1 transition of lvl_i
// The history register resets to RST_VAL; with RST_VAL=1 a button that is
// held through reset does not produce a pulse when reset is released.
module btn_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= lvl_i;
        end
    end

    assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the 3-bit calculator datapath.
// Walks the user through operand A, operand B and operation/direction entry
// (one step per btn_next press), drives the combinational ALU, waits SETTLE
// cycles, captures result and sign, and holds them for the display.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   sw_val, sw_op,
//   sw_dir              - operand / operation / subtract-direction switches
//   btn_next, btn_clr   - advance button and abort/clear (synchronised levels)
//   alu_a, alu_b,
//   alu_op, alu_sub_dir - registered ALU inputs
//   alu_y6, alu_sign    - combinational ALU result
//   res_val, res_neg,
//   res_valid, err_op   - captured result, sign, valid flag, reserved-op flag
//   state_o             - state code for status LEDs
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int SETTLE      = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPND_W-1:0] sw_val,
    input  logic [1:0]        sw_op,
    input  logic              sw_dir,
    input  logic              btn_next,
    input  logic              btn_clr,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    output logic              alu_sub_dir,
    input  logic [RES_W-1:0]  alu_y6,
    input  logic              alu_sign,
    output logic [RES_W-1:0]  res_val,
    output logic              res_neg,
    output logic              res_valid,
    output logic              err_op,
    output logic [2:0]        state_o
);

    localparam logic             HOLD_EN     = (HOLD_CYCLES > 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    logic rise;

    btn_rise #(.RST_VAL(1'b1)) u_next_rise (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (btn_next),
        .rise_o (rise)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic                dir_q, dir_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                neg_q, neg_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; btn_clr overrides everything, including EXEC capture
    always_comb begin
        state_d = state_q;
        if (btn_clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (rise) state_d = S_GET_A;
                S_GET_A:  if (rise) state_d = S_GET_B;
                S_GET_B:  if (rise) state_d = S_GET_OP;
                S_GET_OP: if (rise) state_d = (sw_op == OP_RSV) ? S_SHOW : S_EXEC;
                S_EXEC:   if (cnt_q == SETTLE_LAST) state_d = S_SHOW;
                S_SHOW: begin
                    // A press wins over a coincident timeout
                    if (rise) begin
                        state_d = S_GET_A;
                    end else if (HOLD_EN && cnt_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        dir_d   = dir_q;
        res_d   = res_q;
        neg_d   = neg_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (btn_clr) begin
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            dir_d   = 1'b0;
            res_d   = '0;
            neg_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_GET_A: if (rise) a_d = sw_val;
                S_GET_B: if (rise) b_d = sw_val;
                S_GET_OP: begin
                    if (rise) begin
                        op_d  = sw_op;
                        dir_d = sw_dir;
                        cnt_d = '0;
                        if (sw_op == OP_RSV) begin
                            err_d   = 1'b1;
                            valid_d = 1'b0;
                            res_d   = '0;
                        end
                    end
                end
                S_EXEC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST) begin
                        res_d   = alu_y6;
                        neg_d   = alu_sign & (op_q == OP_SUB);
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                S_SHOW: begin
                    if (HOLD_EN) cnt_d = cnt_q + 1'b1;
                    // Leaving SHOW either way drops the result but keeps operands
                    if (rise || (HOLD_EN && cnt_q == HOLD_LAST)) begin
                        res_d   = '0;
                        neg_d   = 1'b0;
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                S_IDLE: ;
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            dir_q   <= 1'b0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign alu_sub_dir = dir_q;
    assign res_val     = res_q;
    assign res_neg     = neg_q;
    assign res_valid   = valid_q;
    assign err_op      = err_q;
    assign state_o     = state_q;

endmodule
